// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: default datapath width and the
// opcode encodings used by the top-level result mux.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SRL = 3'b100;
    localparam logic [2:0] OP_SRA = 3'b101;

endpackage

// File: rtl/alu_shifter.sv
// Combinational logarithmic barrel right shifter; one stage per shift-amount
// bit. With arith set, vacated bits are filled with the data sign bit.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0]         data,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    input  logic                     arith,
    output logic [WIDTH-1:0]         shifted
);

    localparam int SHW = $clog2(WIDTH);

    logic             fill;
    logic [WIDTH-1:0] stage [SHW+1];

    assign fill     = arith & data[WIDTH-1];
    assign stage[0] = data;

    // Stage gi shifts by 2**gi when the matching shamt bit is set.
    genvar gi;
    generate
        for (gi = 0; gi < SHW; gi++) begin : g_stage
            localparam int SH = 1 << gi;
            assign stage[gi+1] = shamt[gi] ? {{SH{fill}}, stage[gi][WIDTH-1:SH]}
                                           : stage[gi];
        end
    endgenerate

    assign shifted = stage[SHW];

endmodule

// File: rtl/alu_unit.sv
// Registered integer ALU: opcode mux, zero/signed-overflow flags and a
// one-cycle valid strobe, all captured one clock after an accepted operation.
module alu_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUOp,
    output logic [WIDTH-1:0] C,
    output logic             zero,
    output logic             ovf,
    output logic             out_valid
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] result_next;
    logic             ovf_next;

    logic [WIDTH-1:0] c_reg;
    logic             zero_reg;
    logic             ovf_reg;
    logic             valid_reg;

    alu_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .data    (A),
        .shamt   (B[SHW-1:0]),
        .arith   (ALUOp == OP_SRA),
        .shifted (shifted)
    );

    // Overflow only when the operands' effective signs agree and the result sign flips.
    always_comb begin
        result_next = '0;
        ovf_next    = 1'b0;
        case (ALUOp)
            OP_ADD: begin
                result_next = A + B;
                ovf_next    = (A[WIDTH-1] == B[WIDTH-1]) && (result_next[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                result_next = A - B;
                ovf_next    = (A[WIDTH-1] != B[WIDTH-1]) && (result_next[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:         result_next = A & B;
            OP_OR:          result_next = A | B;
            OP_SRL, OP_SRA: result_next = shifted;
            default: begin
                result_next = '0;
                ovf_next    = 1'b0;
            end
        endcase
    end

    // Result and flags hold when no operation is accepted; only the strobe drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_reg     <= '0;
            zero_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= in_valid;
            if (in_valid) begin
                c_reg    <= result_next;
                zero_reg <= (result_next == '0);
                ovf_reg  <= ovf_next;
            end
        end
    end

    assign C         = c_reg;
    assign zero      = zero_reg;
    assign ovf       = ovf_reg;
    assign out_valid = valid_reg;

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: directed cases plus randomized operations
// checked against a plain-arithmetic reference model.
module tb_alu_unit;

    typedef struct {
        logic [31:0] c;
        logic        z;
        logic        o;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [2:0]  ALUOp = '0;
    logic [31:0] C;
    logic        zero;
    logic        ovf;
    logic        out_valid;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   done = 1'b0;

    alu_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .ALUOp     (ALUOp),
        .C         (C),
        .zero      (zero),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: overflow means the exact signed result does not fit in 32 bits.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        exp_t               e;
        longint             sa;
        longint             sbv;
        longint             s;
        logic signed [31:0] as;
        logic [4:0]         sh;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        as  = $signed(a);
        sh  = b[4:0];
        e.o = 1'b0;
        e.due = 0;
        case (op)
            3'd0: begin s = sa + sbv; e.c = a + b; e.o = (s != longint'(int'(s))); end
            3'd1: begin s = sa - sbv; e.c = a - b; e.o = (s != longint'(int'(s))); end
            3'd2: e.c = a & b;
            3'd3: e.c = a | b;
            3'd4: e.c = a >> sh;
            3'd5: e.c = as >>> sh;
            default: e.c = 32'd0;
        endcase
        e.z = (e.c == 32'd0);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Issue one operation; the expected result is due one edge later.
    task automatic drive_exp(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                             input logic [31:0] ec, input logic eo);
        exp_t e;
        @(posedge clk);
        #1;
        A = a; B = b; ALUOp = op; in_valid = 1'b1;
        e.c = ec; e.z = (ec == 32'd0); e.o = eo; e.due = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic drive_rand(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        exp_t e;
        e = model(a, b, op);
        drive_exp(a, b, op, e.c, e.o);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            A = $urandom; B = $urandom; ALUOp = 3'($urandom_range(0, 7));
        end
    endtask

    // Monitor: sole owner of the counters and the scoreboard pop side.
    initial begin
        exp_t        e;
        logic [31:0] hold_c;
        logic        hold_z;
        logic        hold_o;
        hold_c = '0; hold_z = 1'b0; hold_o = 1'b0;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                #1;
                check("reset_c", C, 32'd0);
                check("reset_zero", 32'(zero), 32'd0);
                check("reset_ovf", 32'(ovf), 32'd0);
                check("reset_valid", 32'(out_valid), 32'd0);
                sb.delete();
                hold_c = '0; hold_z = 1'b0; hold_o = 1'b0;
            end else if (out_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got out_valid=1, expected 0 (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    $display("result cycle=%0d C=0x%08h zero=%b ovf=%b", cyc, C, zero, ovf);
                    check("latency", 32'(cyc), 32'(e.due));
                    check("C", C, e.c);
                    check("zero", 32'(zero), 32'(e.z));
                    check("ovf", 32'(ovf), 32'(e.o));
                    hold_c = e.c; hold_z = e.z; hold_o = e.o;
                end
            end else begin
                check("hold_c", C, hold_c);
                check("hold_zero", 32'(zero), 32'(hold_z));
                check("hold_ovf", 32'(ovf), 32'(hold_o));
            end
            if (done) begin
                check("pending_results", 32'(sb.size()), 32'd0);
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // SRA sweep, back to back
        drive_exp(32'hFFFFFFF6, 32'd1, 3'b101, 32'hFFFFFFFB, 1'b0);
        drive_exp(32'hFFFFFFF6, 32'd2, 3'b101, 32'hFFFFFFFD, 1'b0);
        drive_exp(32'hFFFFFFF6, 32'd3, 3'b101, 32'hFFFFFFFE, 1'b0);
        drive_exp(32'hFFFFFFF6, 32'd4, 3'b101, 32'hFFFFFFFF, 1'b0);
        drive_exp(32'hFFFFFFF6, 32'd5, 3'b101, 32'hFFFFFFFF, 1'b0);
        // SRL vs SRA, shift by 0, upper B bits ignored
        drive_exp(32'h80000000, 32'd4, 3'b100, 32'h08000000, 1'b0);
        drive_exp(32'h80000000, 32'd4, 3'b101, 32'hF8000000, 1'b0);
        drive_exp(32'h80000000, 32'hFFFFFFE0, 3'b101, 32'h80000000, 1'b0);
        drive_exp(32'h80000000, 32'h00000024, 3'b100, 32'h08000000, 1'b0);
        // Overflow and zero
        drive_exp(32'h7FFFFFFF, 32'd1, 3'b000, 32'h80000000, 1'b1);
        drive_exp(32'h80000000, 32'd1, 3'b001, 32'h7FFFFFFF, 1'b1);
        drive_exp(32'd5, 32'd5, 3'b001, 32'd0, 1'b0);
        drive_exp(32'hFFFFFFFF, 32'd1, 3'b000, 32'd0, 1'b0);
        // Logic ops and reserved opcodes
        drive_exp(32'hF0F0F0F0, 32'hFF00FF00, 3'b010, 32'hF000F000, 1'b0);
        drive_exp(32'hF0F0F0F0, 32'hFF00FF00, 3'b011, 32'hFFF0FFF0, 1'b0);
        drive_exp(32'h7FFFFFFF, 32'd1, 3'b110, 32'd0, 1'b0);
        drive_exp(32'h12345678, 32'h9, 3'b111, 32'd0, 1'b0);
        // Valid then hold
        drive_exp(32'd3, 32'd4, 3'b000, 32'd7, 1'b0);
        idle(2);

        // Asynchronous reset while a result is being presented
        drive_exp(32'd10, 32'd20, 3'b000, 32'd30, 1'b0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        drive_exp(32'd100, 32'd1, 3'b001, 32'd99, 1'b0);
        idle(1);

        // Randomized operations with occasional idle gaps
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 4))
                0:       a = 32'h7FFFFFFF;
                1:       a = 32'h80000000;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0:       b = 32'h80000000;
                1:       b = a;
                default: b = $urandom;
            endcase
            op = 3'($urandom_range(0, 7));
            drive_rand(a, b, op);
            if ($urandom_range(0, 3) == 0) idle(1);
        end

        idle(4);
        done = 1'b1;
    end

endmodule
